// File: rtl/cmp_result_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmp_result_tracker: audits a 2-bit comparator's gt/lt/eq flags against an
// independent reference and reports per-window class and error counts.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cmp_result_tracker #(
    parameter int WIN = 16,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_a,
    input  logic [1:0]    in_b,
    input  logic          in_gt,
    input  logic          in_lt,
    input  logic          in_eq,
    output logic          rpt_valid,
    input  logic          rpt_ready,
    output logic [CW-1:0] rpt_gt,
    output logic [CW-1:0] rpt_lt,
    output logic [CW-1:0] rpt_eq,
    output logic [CW-1:0] rpt_err,
    output logic          err_pulse
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(WIN - 1);

    state_t        state;
    logic [CW-1:0] cnt_gt, cnt_lt, cnt_eq, cnt_err;
    logic [7:0]    sample_cnt;

    logic          accept;
    logic [2:0]    flags;
    logic [2:0]    ref_flags;
    logic          onehot;
    logic          faulty;
    logic [CW-1:0] nxt_gt, nxt_lt, nxt_eq, nxt_err;

    always_comb begin
        accept    = in_valid && in_ready && (state == COLLECT);
        flags     = {in_gt, in_lt, in_eq};
        ref_flags = {(in_a > in_b), (in_a < in_b), (in_a == in_b)};
        onehot    = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
        // A one-hot flag still counts in its class even when it is wrong.
        faulty    = !onehot || (flags != ref_flags);
        nxt_gt    = cnt_gt  + {{(CW-1){1'b0}}, onehot && in_gt};
        nxt_lt    = cnt_lt  + {{(CW-1){1'b0}}, onehot && in_lt};
        nxt_eq    = cnt_eq  + {{(CW-1){1'b0}}, onehot && in_eq};
        nxt_err   = cnt_err + {{(CW-1){1'b0}}, faulty};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= COLLECT;
            in_ready   <= 1'b0;
            rpt_valid  <= 1'b0;
            err_pulse  <= 1'b0;
            rpt_gt     <= '0;
            rpt_lt     <= '0;
            rpt_eq     <= '0;
            rpt_err    <= '0;
            cnt_gt     <= '0;
            cnt_lt     <= '0;
            cnt_eq     <= '0;
            cnt_err    <= '0;
            sample_cnt <= '0;
        end else begin
            err_pulse <= accept && faulty;
            case (state)
                COLLECT: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        cnt_gt     <= nxt_gt;
                        cnt_lt     <= nxt_lt;
                        cnt_eq     <= nxt_eq;
                        cnt_err    <= nxt_err;
                        sample_cnt <= sample_cnt + 8'd1;
                        if (sample_cnt == LAST_IDX) begin
                            state     <= REPORT;
                            in_ready  <= 1'b0;
                            rpt_valid <= 1'b1;
                            rpt_gt    <= nxt_gt;
                            rpt_lt    <= nxt_lt;
                            rpt_eq    <= nxt_eq;
                            rpt_err   <= nxt_err;
                        end
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        state      <= COLLECT;
                        in_ready   <= 1'b1;
                        rpt_valid  <= 1'b0;
                        rpt_gt     <= '0;
                        rpt_lt     <= '0;
                        rpt_eq     <= '0;
                        rpt_err    <= '0;
                        cnt_gt     <= '0;
                        cnt_lt     <= '0;
                        cnt_eq     <= '0;
                        cnt_err    <= '0;
                        sample_cnt <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_result_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmp_result_tracker: directed scenarios for cmp_result_tracker.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cmp_result_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_a, in_b;
    logic       in_gt, in_lt, in_eq;
    logic       rpt_valid;
    logic       rpt_ready;
    logic [7:0] rpt_gt, rpt_lt, rpt_eq, rpt_err;
    logic       err_pulse;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int rpt_cycles = 0;

    cmp_result_tracker #(.WIN(16), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_gt     (in_gt),
        .in_lt     (in_lt),
        .in_eq     (in_eq),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_gt    (rpt_gt),
        .rpt_lt    (rpt_lt),
        .rpt_eq    (rpt_eq),
        .rpt_err   (rpt_err),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_pulse === 1'b1) err_seen++;
        if (rpt_valid === 1'b1) rpt_cycles++;
    end

    function automatic logic [2:0] good_flags(input logic [1:0] a, input logic [1:0] b);
        return {(a > b), (a < b), (a == b)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one sample for one edge; fl is {gt,lt,eq}.
    task automatic drive_sample(input logic [1:0] a, input logic [1:0] b, input logic [2:0] fl);
        in_a = a; in_b = b;
        {in_gt, in_lt, in_eq} = fl;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; rpt_ready = 1'b0;
        in_a = 2'd0; in_b = 2'd0; {in_gt, in_lt, in_eq} = 3'b000;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0 || rpt_valid !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got in_ready=%b rpt_valid=%b err_pulse=%b expected 0 0 0",
                     in_ready, rpt_valid, err_pulse);
        end
        checks++;
        if ({rpt_gt, rpt_lt, rpt_eq, rpt_err} !== 32'd0) begin
            errors++;
            $display("FAIL reset_rpt: got %h expected 0", {rpt_gt, rpt_lt, rpt_eq, rpt_err});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_exhaustive();
        int e0;
        logic [3:0] iv;
        e0 = err_seen;
        rpt_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            iv = i[3:0];
            drive_sample(iv[3:2], iv[1:0], good_flags(iv[3:2], iv[1:0]));
        end
        checks++;
        if (rpt_valid !== 1'b1 || rpt_gt !== 8'd6 || rpt_lt !== 8'd6 || rpt_eq !== 8'd4 || rpt_err !== 8'd0) begin
            errors++;
            $display("FAIL exhaustive_rpt: got v=%b gt=%0d lt=%0d eq=%0d err=%0d expected 1 6 6 4 0",
                     rpt_valid, rpt_gt, rpt_lt, rpt_eq, rpt_err);
        end
        step();
        checks++;
        if (rpt_valid !== 1'b0 || in_ready !== 1'b1 || rpt_gt !== 8'd0) begin
            errors++;
            $display("FAIL exhaustive_handshake: got v=%b in_ready=%b gt=%0d expected 0 1 0",
                     rpt_valid, in_ready, rpt_gt);
        end
        checks++;
        if (err_seen - e0 !== 0) begin
            errors++;
            $display("FAIL exhaustive_err_pulse: got %0d pulses expected 0", err_seen - e0);
        end
    endtask

    task automatic test_fault();
        int e0;
        logic [3:0] iv;
        logic [2:0] fl;
        e0 = err_seen;
        rpt_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            iv = i[3:0];
            fl = good_flags(iv[3:2], iv[1:0]);
            if (iv == 4'b1001) fl = 3'b001;
            if (iv == 4'b1111) fl = 3'b000;
            drive_sample(iv[3:2], iv[1:0], fl);
        end
        checks++;
        if (rpt_gt !== 8'd5 || rpt_lt !== 8'd6 || rpt_eq !== 8'd4 || rpt_err !== 8'd2) begin
            errors++;
            $display("FAIL fault_rpt: got gt=%0d lt=%0d eq=%0d err=%0d expected 5 6 4 2",
                     rpt_gt, rpt_lt, rpt_eq, rpt_err);
        end
        step();
        checks++;
        if (err_seen - e0 !== 2) begin
            errors++;
            $display("FAIL fault_err_pulse: got %0d pulses expected 2", err_seen - e0);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] iv;
        rpt_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            iv = i[3:0];
            drive_sample(iv[3:2], iv[1:0], good_flags(iv[3:2], iv[1:0]));
        end
        checks++;
        if (rpt_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_rpt_valid: got %b expected 1", rpt_valid);
        end
        // Offer faulty samples while stalled; they must not be taken.
        in_valid = 1'b1; in_a = 2'd1; in_b = 2'd2; {in_gt, in_lt, in_eq} = 3'b111;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (rpt_valid !== 1'b1 || in_ready !== 1'b0 || err_pulse !== 1'b0 ||
                rpt_gt !== 8'd6 || rpt_lt !== 8'd6 || rpt_eq !== 8'd4 || rpt_err !== 8'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b ep=%b gt=%0d lt=%0d eq=%0d err=%0d expected 1 0 0 6 6 4 0",
                         c, rpt_valid, in_ready, err_pulse, rpt_gt, rpt_lt, rpt_eq, rpt_err);
            end
        end
        in_valid = 1'b0;
        rpt_ready = 1'b1;
        step();
        checks++;
        if (rpt_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got v=%b in_ready=%b expected 0 1", rpt_valid, in_ready);
        end
        for (int i = 0; i < 16; i++) drive_sample(2'd2, 2'd2, 3'b001);
        checks++;
        if (rpt_valid !== 1'b1 || rpt_gt !== 8'd0 || rpt_lt !== 8'd0 || rpt_eq !== 8'd16 || rpt_err !== 8'd0) begin
            errors++;
            $display("FAIL bp_restart: got v=%b gt=%0d lt=%0d eq=%0d err=%0d expected 1 0 0 16 0",
                     rpt_valid, rpt_gt, rpt_lt, rpt_eq, rpt_err);
        end
        step();
    endtask

    task automatic test_gapped();
        int r0;
        logic [3:0] iv;
        rpt_ready = 1'b1;
        r0 = rpt_cycles;
        for (int i = 0; i < 16; i++) begin
            iv = i[3:0];
            drive_sample(iv[3:2], iv[1:0], good_flags(iv[3:2], iv[1:0]));
            if (i < 15) step();
            if (i == 14) begin
                checks++;
                if (rpt_valid !== 1'b0 || rpt_cycles != r0) begin
                    errors++;
                    $display("FAIL gapped_early: got v=%b cycles=%0d expected 0 0", rpt_valid, rpt_cycles - r0);
                end
            end
        end
        checks++;
        if (rpt_valid !== 1'b1 || rpt_gt !== 8'd6 || rpt_lt !== 8'd6 || rpt_eq !== 8'd4 || rpt_err !== 8'd0) begin
            errors++;
            $display("FAIL gapped_rpt: got v=%b gt=%0d lt=%0d eq=%0d err=%0d expected 1 6 6 4 0",
                     rpt_valid, rpt_gt, rpt_lt, rpt_eq, rpt_err);
        end
        step();
    endtask

    task automatic test_reset_mid_window();
        int r0;
        rpt_ready = 1'b1;
        r0 = rpt_cycles;
        for (int i = 0; i < 9; i++) drive_sample(2'd0, 2'd1, 3'b010);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) drive_sample(2'd3, 2'd0, 3'b100);
        checks++;
        if (rpt_valid !== 1'b1 || rpt_gt !== 8'd16 || rpt_lt !== 8'd0 || rpt_eq !== 8'd0 || rpt_err !== 8'd0) begin
            errors++;
            $display("FAIL midwin_rpt: got v=%b gt=%0d lt=%0d eq=%0d err=%0d expected 1 16 0 0 0",
                     rpt_valid, rpt_gt, rpt_lt, rpt_eq, rpt_err);
        end
        step();
        checks++;
        if (rpt_cycles - r0 !== 1) begin
            errors++;
            $display("FAIL midwin_report_count: got %0d expected 1", rpt_cycles - r0);
        end
    endtask

    task automatic test_reset_in_report();
        int r0;
        rpt_ready = 1'b0;
        for (int i = 0; i < 16; i++) drive_sample(2'd1, 2'd3, 3'b010);
        checks++;
        if (rpt_valid !== 1'b1 || rpt_lt !== 8'd16) begin
            errors++;
            $display("FAIL rptrst_pre: got v=%b lt=%0d expected 1 16", rpt_valid, rpt_lt);
        end
        rst_n = 1'b0;
        step();
        r0 = rpt_cycles;
        checks++;
        if (rpt_valid !== 1'b0 || rpt_lt !== 8'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rptrst_flush: got v=%b lt=%0d in_ready=%b expected 0 0 0", rpt_valid, rpt_lt, in_ready);
        end
        rst_n = 1'b1;
        rpt_ready = 1'b1;
        step();
        step();
        step();
        checks++;
        if (rpt_cycles != r0 || rpt_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rptrst_after: got cycles=%0d v=%b in_ready=%b expected 0 0 1",
                     rpt_cycles - r0, rpt_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_fault();
        test_backpressure();
        test_gapped();
        test_reset_mid_window();
        test_reset_in_report();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
